// File: rtl/controle_estados.sv
// Multicycle sequencer for the RISC-V datapath: drives the shared 4-bit estado bus, cycle/retire counters.
// Optional macro CONTROLE_ATRASO_EN inserts the AUX1..AUX4 settle states around MEM and WB.
module controle_estados #(
  parameter int LARGURA_CONT = 32,
  parameter int MAX_ESPERA   = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             instrucao,
  input  logic [2:0]              tipo,
  input  logic                    mem_pronto,
  output logic [3:0]              estado,
  output logic                    pc_en,
  output logic                    fim,
  output logic                    erro,
  output logic [LARGURA_CONT-1:0] ciclos,
  output logic [LARGURA_CONT-1:0] instr_cont
);

  localparam logic [3:0] S_IF    = 4'b0000;
  localparam logic [3:0] S_ID    = 4'b0001;
  localparam logic [3:0] S_EX    = 4'b0010;
  localparam logic [3:0] S_MEM   = 4'b0011;
  localparam logic [3:0] S_WB    = 4'b0100;
  localparam logic [3:0] S_AUX1  = 4'b0101;
  localparam logic [3:0] S_AUX3  = 4'b0110;
  localparam logic [3:0] S_AUX4  = 4'b0111;
  localparam logic [3:0] S_SUMPC = 4'b1000;
  localparam logic [3:0] S_FIM   = 4'b1001;
  localparam logic [3:0] S_AUX2  = 4'b1111;

  localparam logic [7:0] ESPERA_MAX = 8'(MAX_ESPERA);

  logic [3:0] proximo;
  logic [7:0] espera;
  logic [7:0] espera_prox;
  logic       timeout;
  logic       eh_mem;
  logic       ilegal;

  assign eh_mem = (tipo == 3'b010) || (tipo == 3'b011);
  assign ilegal = (estado >= 4'b1010) && (estado != S_AUX2);

  // espera defaults to zero so it clears on every MEM entry and exit; it only counts while held in MEM
  always_comb begin
    proximo     = S_IF;
    espera_prox = 8'd0;
    timeout     = 1'b0;
    case (estado)
      S_IF:  proximo = S_ID;
      S_ID:  proximo = (instrucao == 32'h0) ? S_FIM : S_EX;
`ifdef CONTROLE_ATRASO_EN
      S_EX:  proximo = S_AUX1;
`else
      S_EX:  proximo = S_MEM;
`endif
      S_AUX1: proximo = S_AUX2;
      S_AUX2: proximo = S_MEM;
      S_MEM: begin
        if (!eh_mem || mem_pronto) begin
          proximo = S_WB;
        end else if (espera == ESPERA_MAX) begin
          proximo = S_FIM;
          timeout = 1'b1;
        end else begin
          proximo     = S_MEM;
          espera_prox = espera + 8'd1;
        end
      end
`ifdef CONTROLE_ATRASO_EN
      S_WB:  proximo = S_AUX3;
`else
      S_WB:  proximo = S_SUMPC;
`endif
      S_AUX3:  proximo = S_AUX4;
      S_AUX4:  proximo = S_SUMPC;
      S_SUMPC: proximo = S_IF;
      S_FIM:   proximo = S_FIM;
      default: proximo = S_IF;
    endcase
  end

  // Flags are registered from the next state so they change only on the edge that changes estado
  always_ff @(posedge clk) begin
    if (rst) begin
      estado     <= S_IF;
      espera     <= 8'd0;
      pc_en      <= 1'b0;
      fim        <= 1'b0;
      erro       <= 1'b0;
      ciclos     <= '0;
      instr_cont <= '0;
    end else begin
      estado <= proximo;
      espera <= espera_prox;
      pc_en  <= (proximo == S_SUMPC);
      fim    <= (proximo == S_FIM);
      if (timeout) begin
        erro <= 1'b1;
      end
      if ((estado != S_FIM) && !ilegal && (ciclos != '1)) begin
        ciclos <= ciclos + LARGURA_CONT'(1);
      end
      if ((estado == S_SUMPC) && (instr_cont != '1)) begin
        instr_cont <= instr_cont + LARGURA_CONT'(1);
      end
    end
  end

endmodule

// File: tb/tb_controle_estados.sv
// Self-checking bench for controle_estados: programs are expanded into per-cycle expected traces
// by a behavioural model, then replayed against the DUT with randomized don't-care inputs.
module tb_controle_estados;

  localparam int MAX = 15;
`ifdef CONTROLE_ATRASO_EN
  localparam bit ATRASO = 1'b1;
`else
  localparam bit ATRASO = 1'b0;
`endif
  localparam int L = ATRASO ? 10 : 6;

  localparam logic [3:0] ST_IF = 4'd0, ST_ID = 4'd1, ST_EX = 4'd2, ST_MEM = 4'd3, ST_WB = 4'd4;
  localparam logic [3:0] ST_AUX1 = 4'd5, ST_AUX3 = 4'd6, ST_AUX4 = 4'd7, ST_SUMPC = 4'd8;
  localparam logic [3:0] ST_FIM = 4'd9, ST_AUX2 = 4'd15;

  localparam int K_ALU = 0, K_MEM = 1, K_TMO = 2, K_ZERO = 3;

  logic        clk;
  logic        rst;
  logic [31:0] instrucao;
  logic [2:0]  tipo;
  logic        mem_pronto;
  logic [3:0]  estado;
  logic        pc_en;
  logic        fim;
  logic        erro;
  logic [31:0] ciclos;
  logic [31:0] instr_cont;

  controle_estados #(.LARGURA_CONT(32), .MAX_ESPERA(MAX)) dut (
    .clk(clk), .rst(rst), .instrucao(instrucao), .tipo(tipo), .mem_pronto(mem_pronto),
    .estado(estado), .pc_en(pc_en), .fim(fim), .erro(erro), .ciclos(ciclos), .instr_cont(instr_cont)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic        rst_in;
    logic        mp;
    logic [31:0] ins;
    logic [2:0]  tp;
    logic [31:0] cyc;
    logic [31:0] ret;
    logic        err;
  } vec_t;

  vec_t        prog[$];
  int          cyc_cnt, ret_cnt;
  bit          err_m;
  int          vectors, miscompares, checks;
  logic [3:0]  obs_st[$];
  logic [31:0] obs_cyc[$], obs_ret[$];
  logic        obs_pc[$], obs_fim[$], obs_err[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] rand_word();
    return ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom();
  endfunction

  function automatic logic [2:0] rand_alu_tipo();
    logic [2:0] t;
    do t = 3'($urandom_range(0, 7)); while (t == 3'b010 || t == 3'b011);
    return t;
  endfunction

  // Model bookkeeping: a cycle spent in state st shows the counters accumulated so far
  task automatic push_vec(input logic [3:0] st, input logic mp, input logic [31:0] ins,
                          input logic [2:0] tp, input bit do_rst, input bit set_err);
    vec_t v;
    v.st = st; v.mp = mp; v.ins = ins; v.tp = tp; v.rst_in = do_rst;
    v.cyc = 32'(cyc_cnt); v.ret = 32'(ret_cnt); v.err = err_m;
    prog.push_back(v);
    if (do_rst) begin
      cyc_cnt = 0; ret_cnt = 0; err_m = 1'b0;
    end else begin
      if (st != ST_FIM) cyc_cnt++;
      if (st == ST_SUMPC) ret_cnt++;
      if (set_err) err_m = 1'b1;
    end
  endtask

  // abort > 0 asserts rst during the abort-th cycle of the instruction
  task automatic add_instr(input int kind, input int k, input int abort);
    logic [3:0]  s[$];
    logic        m[$];
    logic [31:0] w;
    logic [2:0]  t;
    if (kind == K_ZERO) w = 32'h0;
    else do w = $urandom(); while (w == 32'h0);
    t = (kind == K_ALU || kind == K_ZERO) ? rand_alu_tipo() : (($urandom_range(0, 1) == 0) ? 3'b010 : 3'b011);
    s.push_back(ST_IF); m.push_back(1'($urandom_range(0, 1)));
    s.push_back(ST_ID); m.push_back(1'($urandom_range(0, 1)));
    if (kind != K_ZERO) begin
      s.push_back(ST_EX); m.push_back(1'($urandom_range(0, 1)));
      if (ATRASO) begin
        s.push_back(ST_AUX1); m.push_back(1'($urandom_range(0, 1)));
        s.push_back(ST_AUX2); m.push_back(1'($urandom_range(0, 1)));
      end
      if (kind == K_ALU) begin
        s.push_back(ST_MEM); m.push_back(1'($urandom_range(0, 1)));
      end else if (kind == K_MEM) begin
        for (int i = 0; i < k; i++) begin s.push_back(ST_MEM); m.push_back(1'b0); end
        s.push_back(ST_MEM); m.push_back(1'b1);
      end else begin
        for (int i = 0; i <= MAX; i++) begin s.push_back(ST_MEM); m.push_back(1'b0); end
      end
      if (kind != K_TMO) begin
        s.push_back(ST_WB); m.push_back(1'($urandom_range(0, 1)));
        if (ATRASO) begin
          s.push_back(ST_AUX3); m.push_back(1'($urandom_range(0, 1)));
          s.push_back(ST_AUX4); m.push_back(1'($urandom_range(0, 1)));
        end
        s.push_back(ST_SUMPC); m.push_back(1'($urandom_range(0, 1)));
      end
    end
    for (int i = 0; i < s.size(); i++) begin
      push_vec(s[i], m[i], (s[i] == ST_ID) ? w : rand_word(),
               (s[i] == ST_MEM) ? t : 3'($urandom_range(0, 7)),
               (abort > 0) && (i == abort - 1),
               (kind == K_TMO) && (i == s.size() - 1));
      if ((abort > 0) && (i == abort - 1)) break;
    end
  endtask

  task automatic add_fim(input int n);
    for (int i = 0; i < n; i++)
      push_vec(ST_FIM, 1'($urandom_range(0, 1)), rand_word(), 3'($urandom_range(0, 7)), i == n - 1, 1'b0);
  endtask

  task automatic checkOutput(input vec_t v);
    check("estado", 32'(estado), 32'(v.st));
    check("pc_en", 32'(pc_en), 32'(v.st == ST_SUMPC));
    check("fim", 32'(fim), 32'(v.st == ST_FIM));
    check("erro", 32'(erro), 32'(v.err));
    check("ciclos", ciclos, v.cyc);
    check("instr_cont", instr_cont, v.ret);
    obs_st.push_back(estado); obs_cyc.push_back(ciclos); obs_ret.push_back(instr_cont);
    obs_pc.push_back(pc_en); obs_fim.push_back(fim); obs_err.push_back(erro);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst_in; mem_pronto = v.mp; instrucao = v.ins; tipo = v.tp;
  endtask

  task automatic run_prog();
    obs_st.delete(); obs_cyc.delete(); obs_ret.delete();
    obs_pc.delete(); obs_fim.delete(); obs_err.delete();
    foreach (prog[i]) begin
      @(negedge clk);
      vectors++;
      checkOutput(prog[i]);
      applyStimulus(prog[i]);
    end
    prog.delete();
  endtask

  initial begin
    int seq[$];
    int cnt, first_fim, j;
    vectors = 0; miscompares = 0; checks = 0;
    cyc_cnt = 0; ret_cnt = 0; err_m = 1'b0;
    rst = 1'b1; mem_pronto = 1'b0; instrucao = 32'h0; tipo = 3'b000;
    repeat (2) @(posedge clk);

    // addi, sub, zero word: literal trace and counters at FIM entry
    add_instr(K_ALU, 0, 0); add_instr(K_ALU, 0, 0); add_instr(K_ZERO, 0, 0); add_fim(3);
    run_prog();
    for (int r = 0; r < 2; r++) begin
      if (ATRASO) seq = {seq, 0, 1, 2, 5, 15, 3, 4, 6, 7, 8};
      else        seq = {seq, 0, 1, 2, 3, 4, 8};
    end
    seq = {seq, 0, 1, 9};
    foreach (seq[i]) check("lit_trace", 32'(obs_st[i]), 32'(seq[i]));
    first_fim = -1; cnt = 0;
    foreach (obs_st[i]) begin
      if (obs_st[i] == ST_FIM && first_fim < 0) first_fim = i;
      if (obs_pc[i]) cnt++;
    end
    check("lit_fim_index", 32'(first_fim), 32'(ATRASO ? 22 : 14));
    check("lit_ciclos_fim", obs_cyc[first_fim], ATRASO ? 32'd22 : 32'd14);
    check("lit_instr_fim", obs_ret[first_fim], 32'd2);
    check("lit_pc_en_count", 32'(cnt), 32'd2);

    // lw with three not-ready cycles
    add_instr(K_MEM, 3, 0); add_instr(K_ZERO, 0, 0); add_fim(2);
    run_prog();
    cnt = 0;
    foreach (obs_st[i]) if (obs_st[i] == ST_MEM) cnt++;
    check("lit_lw_mem_cycles", 32'(cnt), 32'd4);
    check("lit_lw_next_if", 32'(obs_st[L + 3]), 32'(ST_IF));
    check("lit_lw_sumpc", 32'(obs_st[L + 2]), 32'(ST_SUMPC));
    check("lit_lw_erro", 32'(obs_err[obs_err.size() - 1]), 32'd0);

    // ready on the timeout cycle, then a real timeout ending in FIM
    add_instr(K_MEM, MAX, 0); add_instr(K_TMO, 0, 0); add_fim(4);
    run_prog();
    cnt = 0;
    foreach (obs_st[i]) if (obs_st[i] == ST_MEM) cnt++;
    check("lit_tmo_mem_cycles", 32'(cnt), 32'(2 * (MAX + 1)));
    check("lit_ready_wins_ret", obs_ret[L + MAX], 32'd1);
    check("lit_tmo_fim", 32'(obs_fim[obs_fim.size() - 1]), 32'd1);
    check("lit_tmo_erro", 32'(obs_err[obs_err.size() - 1]), 32'd1);

    // reset in the middle of the sixth instruction, then reset from FIM
    for (int i = 0; i < 5; i++) add_instr(K_ALU, 0, 0);
    add_instr(K_ALU, 0, ATRASO ? 5 : 3);
    add_instr(K_TMO, 0, 0); add_fim(2);
    run_prog();
    j = 5 * L + (ATRASO ? 4 : 2);
    check("lit_abort_state", 32'(obs_st[j]), 32'(ATRASO ? ST_AUX2 : ST_EX));
    check("lit_abort_ret", obs_ret[j], 32'd5);
    check("lit_after_rst_st", 32'(obs_st[j + 1]), 32'(ST_IF));
    check("lit_after_rst_cyc", obs_cyc[j + 1], 32'd0);
    check("lit_after_rst_ret", obs_ret[j + 1], 32'd0);

    // randomized programs
    for (int n = 0; n < 80; n++) begin
      int sel;
      sel = $urandom_range(0, 19);
      if (sel < 9) add_instr(K_ALU, 0, ($urandom_range(0, 9) == 0) ? $urandom_range(1, 10) : 0);
      else if (sel < 16) add_instr(K_MEM, ($urandom_range(0, 4) == 0) ? MAX : $urandom_range(0, MAX),
                                   ($urandom_range(0, 9) == 0) ? $urandom_range(1, 12) : 0);
      else if (sel < 18) begin add_instr(K_ZERO, 0, 0); add_fim($urandom_range(1, 4)); end
      else begin add_instr(K_TMO, 0, 0); add_fim($urandom_range(1, 4)); end
    end
    add_instr(K_ZERO, 0, 0); add_fim(2);
    run_prog();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
